// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the hazard/interlock logic.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO       = 5'd0;
  localparam int         MD_TIMEOUT_DEF = 40;

endpackage

// File: rtl/md_wait_timer.sv
// Counts multdiv WAIT cycles; expired is high in the cycle the count reaches MD_TIMEOUT-1.
// One-cycle latency from enable to count; clear has priority over enable.
module md_wait_timer
  import cpu_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: load-use bubble, taken-branch squash, multdiv start/freeze/timeout.
// Outputs are combinational in the same cycle; multdiv holds the front end until md_ready or timeout.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] fd_rs,
  input  logic [4:0] fd_rt,
  input  logic       fd_reads_rt,
  input  logic [4:0] dx_rd,
  input  logic       dx_is_lw,
  input  logic       dx_is_md,
  input  logic       branch_taken,
  input  logic       md_ready,
  output logic       md_start,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       hold_dx,
  output logic       nop_dx,
  output logic       flush_fd,
  output logic       nop_xm,
  output logic       md_result_valid,
  output logic       md_err,
  output logic       md_timeout
);

  hz_state_e state_q, state_d;
  logic      timeout_q, timeout_d;
  logic      lu, cnt_clear, cnt_en, cnt_expired;

  assign lu = dx_is_lw && (dx_rd != REG_ZERO) &&
              ((fd_rs == dx_rd) || (fd_reads_rt && (fd_rt == dx_rd)));

  md_wait_timer #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_md_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d         = state_q;
    timeout_d       = timeout_q;
    cnt_clear       = 1'b0;
    cnt_en          = 1'b0;
    md_start        = 1'b0;
    stall_pc        = 1'b0;
    stall_fd        = 1'b0;
    hold_dx         = 1'b0;
    nop_dx          = 1'b0;
    flush_fd        = 1'b0;
    nop_xm          = 1'b0;
    md_result_valid = 1'b0;
    md_err          = 1'b0;
    md_timeout      = timeout_q;

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        // Branch beats both md and load-use so the PC is free to load the target.
        if (branch_taken) begin
          flush_fd = 1'b1;
          nop_dx   = 1'b1;
        end else if (dx_is_md) begin
          md_start = 1'b1;
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          hold_dx  = 1'b1;
          nop_xm   = 1'b1;
          state_d  = WAIT;
        end else if (lu) begin
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          nop_dx   = 1'b1;
        end
      end
      WAIT: begin
        if (md_ready) begin
          md_result_valid = 1'b1;
          state_d         = IDLE;
        end else if (cnt_expired) begin
          md_result_valid = 1'b1;
          md_err          = 1'b1;
          timeout_d       = 1'b1;
          state_d         = IDLE;
        end else begin
          stall_pc = 1'b1;
          stall_fd = 1'b1;
          hold_dx  = 1'b1;
          nop_xm   = 1'b1;
          cnt_en   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (reset) begin
      md_start        = 1'b0;
      stall_pc        = 1'b0;
      stall_fd        = 1'b0;
      hold_dx         = 1'b0;
      nop_dx          = 1'b0;
      flush_fd        = 1'b0;
      nop_xm          = 1'b0;
      md_result_valid = 1'b0;
      md_err          = 1'b0;
      md_timeout      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: expected output vectors are queued as stimulus is driven and checked each cycle.
module tb_hazard_ctrl;

  logic       clock, reset;
  logic [4:0] fd_rs, fd_rt, dx_rd;
  logic       fd_reads_rt, dx_is_lw, dx_is_md, branch_taken, md_ready;
  logic       md_start, stall_pc, stall_fd, hold_dx, nop_dx, flush_fd, nop_xm;
  logic       md_result_valid, md_err, md_timeout;

  // Vector order: md_start stall_pc stall_fd hold_dx nop_dx flush_fd nop_xm md_result_valid md_err md_timeout
  localparam logic [9:0] NONE  = 10'b0000000000;
  localparam logic [9:0] START = 10'b1111001000;
  localparam logic [9:0] HOLD  = 10'b0111001000;
  localparam logic [9:0] LU    = 10'b0110100000;
  localparam logic [9:0] BR    = 10'b0000110000;
  localparam logic [9:0] DONE  = 10'b0000000100;
  localparam logic [9:0] ERRV  = 10'b0000000110;
  localparam logic [9:0] TMO   = 10'b0000000001;

  logic [9:0] exp_q[$];
  logic [9:0] got, want;
  int         n_vec, n_bad;

  hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .fd_rs          (fd_rs),
    .fd_rt          (fd_rt),
    .fd_reads_rt    (fd_reads_rt),
    .dx_rd          (dx_rd),
    .dx_is_lw       (dx_is_lw),
    .dx_is_md       (dx_is_md),
    .branch_taken   (branch_taken),
    .md_ready       (md_ready),
    .md_start       (md_start),
    .stall_pc       (stall_pc),
    .stall_fd       (stall_fd),
    .hold_dx        (hold_dx),
    .nop_dx         (nop_dx),
    .flush_fd       (flush_fd),
    .nop_xm         (nop_xm),
    .md_result_valid(md_result_valid),
    .md_err         (md_err),
    .md_timeout     (md_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] dut_outs();
    return {md_start, stall_pc, stall_fd, hold_dx, nop_dx, flush_fd, nop_xm,
            md_result_valid, md_err, md_timeout};
  endfunction

  task automatic clear_inputs();
    fd_rs = 5'd0; fd_rt = 5'd0; fd_reads_rt = 1'b0; dx_rd = 5'd0;
    dx_is_lw = 1'b0; dx_is_md = 1'b0; branch_taken = 1'b0; md_ready = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic reads_rt);
    dx_is_lw = 1'b1; dx_rd = rd; fd_rs = rs; fd_rt = rt; fd_reads_rt = reads_rt;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      reset = (i < 2);
      set_lw(5'd5, 5'd5, 5'd0, 1'b0);
      dx_is_md = (i < 2);
      md_ready = (i == 1);
      exp_q.push_back((i < 2) ? NONE : LU);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_use();
    logic [9:0] e;
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      case (i)
        0: begin set_lw(5'd5, 5'd5, 5'd9, 1'b1); e = LU;   end
        1: begin fd_rs = 5'd5;                    e = NONE; end
        2: begin set_lw(5'd7, 5'd1, 5'd7, 1'b1); e = LU;   end
        3: begin set_lw(5'd0, 5'd0, 5'd0, 1'b1); e = NONE; end
        4: begin set_lw(5'd5, 5'd2, 5'd5, 1'b0); e = NONE; end
        default: begin set_lw(5'd5, 5'd6, 5'd7, 1'b1); e = NONE; end
      endcase
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL load_use c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch();
    logic [9:0] e;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      case (i)
        0: begin set_lw(5'd5, 5'd5, 5'd0, 1'b0); branch_taken = 1'b1; e = BR; end
        1: begin dx_is_md = 1'b1; branch_taken = 1'b1; e = BR; end
        default: begin md_ready = 1'b1; e = NONE; end
      endcase
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL branch c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_md_ready();
    logic [9:0] e;
    for (int i = 0; i < 19; i++) begin
      clear_inputs();
      dx_is_md = (i <= 17);
      if (i == 0) begin
        md_ready = 1'b1; e = START;
      end else if (i < 17) begin
        e = HOLD;
        if (i == 5) branch_taken = 1'b1;
        if (i == 6) set_lw(5'd3, 5'd3, 5'd0, 1'b0);
      end else if (i == 17) begin
        md_ready = 1'b1; e = DONE;
      end else begin
        e = NONE;
      end
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL md_ready c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      dx_is_md = (i < 4);
      md_ready = (i == 1) || (i == 3) || (i == 4);
      e = (i == 0 || i == 2) ? START : (i == 4) ? NONE : DONE;
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL back_to_back c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_timeout();
    logic [9:0] e;
    for (int i = 0; i < 44; i++) begin
      clear_inputs();
      dx_is_md = (i <= 40);
      if (i == 0)       e = START;
      else if (i < 40)  e = HOLD;
      else if (i == 40) e = ERRV;
      else if (i == 41) e = TMO;
      else if (i == 42) begin set_lw(5'd4, 5'd0, 5'd4, 1'b1); e = LU | TMO; end
      else begin md_ready = 1'b1; e = TMO; end
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL timeout c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [9:0] e;
    for (int i = 0; i < 9; i++) begin
      clear_inputs();
      reset = (i == 5);
      dx_is_md = (i <= 5);
      if (i == 0)      e = START | TMO;
      else if (i < 5)  e = HOLD | TMO;
      else if (i == 5) e = NONE;
      else begin md_ready = 1'b1; e = NONE; end
      exp_q.push_back(e);
      @(negedge clock);
      got = dut_outs(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_mid_wait c%0d got=%b want=%b", i, got, want);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_md_ready();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock unit: the stall/flush counterpart of the forwarding unit. It covers the hazards that forwarding cannot resolve.
- Detects load-use hazards between the FD and DX stages and inserts one bubble.
- Sequences multi-cycle mult/div operations: issues the start pulse, freezes PC/FD/DX, bubbles XM, and times out a hung unit.
- Squashes wrong-path instructions on a taken branch or jump resolved in X.

Parameters:
- MD_TIMEOUT, 40: maximum number of WAIT cycles without md_ready before the operation is aborted.
- CNT_W, 6: width of the wait counter. Must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  processor clock, single clock domain.
- reset  in  1  synchronous, active-high.
- fd_rs  in  5  rs field of the instruction in FD.
- fd_rt  in  5  rt field of the instruction in FD.
- fd_reads_rt  in  1  FD instruction reads rt (R-type, sw data, bne/blt).
- dx_rd  in  5  destination register of the instruction in DX.
- dx_is_lw  in  1  DX holds a lw.
- dx_is_md  in  1  DX holds mul or div.
- branch_taken  in  1  taken branch or jump resolved in DX this cycle.
- md_ready  in  1  multdiv result valid (one-cycle pulse).
- md_start  out  1  one-cycle start pulse to multdiv.
- stall_pc  out  1  hold PC.
- stall_fd  out  1  hold FD latch.
- hold_dx  out  1  hold DX latch.
- nop_dx  out  1  load nop into DX latch.
- flush_fd  out  1  load nop into FD latch.
- nop_xm  out  1  load nop into XM latch.
- md_result_valid  out  1  XM latch captures the multdiv result this edge.
- md_err  out  1  one-cycle pulse: timeout abort; result forced to 0, rstatus written by downstream.
- md_timeout  out  1  sticky flag, set on the first timeout, cleared only by reset.

Behaviour:
- FSM states: IDLE, WAIT. Counter cnt is CNT_W bits wide. All outputs are combinational from state, cnt and inputs, and are forced to 0 while reset=1.
- Reset: state=IDLE, cnt=0, md_timeout=0. Reset asserted mid-WAIT aborts immediately, with no md_err. The multdiv unit is reset by its own path.
- Load-use hazard: lu = dx_is_lw && dx_rd!=0 && (fd_rs==dx_rd || (fd_reads_rt && fd_rt==dx_rd)).
  - lu produces stall_pc=stall_fd=nop_dx=1 for exactly one cycle.
  - Next cycle the lw is in XM, DX holds the bubble, and forwarding covers the dependency.
- Branch: branch_taken=1 gives flush_fd=1 and nop_dx=1 in that cycle. It overrides lu; stall_pc=0 so the PC loads the target.
- Multdiv start (IDLE):
  - Trigger: dx_is_md && !branch_taken. This gives md_start=1 and hold_dx=stall_fd=stall_pc=nop_xm=1, then moves to WAIT with cnt=0.
  - md_ready in the start cycle is ignored.
  - If dx_is_md and branch_taken are both 1 (illegal), the branch wins and md_start=0.
- WAIT, md_ready=0:
  - hold_dx=stall_fd=stall_pc=nop_xm=1; cnt increments.
  - If cnt==MD_TIMEOUT-1 this cycle: release all holds, md_result_valid=1, md_err=1, md_timeout<=1, then go to IDLE.
- WAIT, md_ready=1: all holds released, md_result_valid=1, nop_xm=0, then go to IDLE. The md instruction leaves DX on this edge, so it is never restarted.
- Back-to-back md: the next md reaches DX one cycle later and restarts from IDLE normally. There is a minimum of one free cycle between md operations.
- lu and branch_taken are ignored while state=WAIT, since the DX/FD contents are frozen.
- md_ready while IDLE (spurious) is ignored; no outputs change.
- Latency: load-use costs 1 bubble; branch costs 2 squashed slots; md costs N+1 stall cycles, where N is the number of cycles until md_ready.

Decomposition:
- Shared package cpu_pkg holds:
  - hazard state enum (IDLE=1'b0, WAIT=1'b1);
  - REG_ZERO=5'd0;
  - MD_TIMEOUT default.
- The opcode decode for dx_is_lw, dx_is_md and fd_reads_rt stays in the existing decode logic.
- One sub-module: md_wait_timer (cnt, clear, enable, expired compare). Everything else is inline.

Test Plan:
- lw $5 in DX; FD add reads rs=$5 -> stall_pc=stall_fd=nop_dx=1 for exactly 1 cycle, then 0.
- lw $0 in DX; FD reads $0 -> no stall. lw $5 in DX; FD reads rt=$5 with fd_reads_rt=0 -> no stall.
- branch_taken=1 with lu also true -> flush_fd=nop_dx=1, stall_pc=0.
- mul in DX; md_ready pulsed on the 17th WAIT cycle -> md_start=1 in cycle 0 only; holds and nop_xm=1 for 17 cycles; md_result_valid=1 in the ready cycle; IDLE next cycle.
- mul in DX; md_ready never arrives -> md_err pulse and md_result_valid=1 at WAIT cycle 40; md_timeout stays 1 until reset.
- Reset asserted at WAIT cycle 5 -> next cycle state=IDLE, all outputs 0, md_err never pulses.
